jts16_shadow_dump: RTL
======================

JTS16_SHADOW_DUMP -- requirements
Module: jts16_shadow_dump

Interface
REQ-001 SHALL have parameter WAIT, default 2: clock edges ioctl_addr is held stable before ioctl_din is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1: one-cycle request to begin a dump.
REQ-005 SHALL have port abort  input  1: cancels a dump in progress.
REQ-006 SHALL have port region_en  input  4: bit0 VRAM, bit1 char, bit2 palette, bit3 object RAM; sampled only when start is accepted.
REQ-007 SHALL have port ioctl_addr  output  16: byte address presented to the shadow RAM read port.
REQ-008 SHALL have port ioctl_din  input  8: byte returned by the shadow RAM read port.
REQ-009 SHALL have port dout  output  8: captured byte.
REQ-010 SHALL have port dout_valid  output  1: dout holds a byte not yet accepted.
REQ-011 SHALL have port dout_ready  input  1: consumer accepts dout when high with dout_valid.
REQ-012 SHALL have port dout_last  output  1: qualifies the final byte of the dump.
REQ-013 SHALL have port busy  output  1: dump in progress.
REQ-014 SHALL have port done  output  1: one-cycle pulse on normal completion.

Function
REQ-015 SHALL use region map: VRAM 0x0000-0x7FFF, char 0x8000-0x8FFF, palette 0x9000-0x9FFF, object 0xA000-0xA7FF; order VRAM, char, palette, object; disabled regions skipped entirely.
REQ-016 SHALL implement states IDLE, SEEK, ADDR, SAMPLE, HOLD, FINISH.
REQ-017 IDLE: start=1 with abort=0 -> latch region_en, assert busy next cycle, go SEEK; start while not IDLE SHALL be ignored.
REQ-018 SEEK (one cycle): select lowest-order enabled region not yet dumped, load its base into ioctl_addr, go ADDR; if none remain -> FINISH.
REQ-019 ADDR: hold ioctl_addr for WAIT edges via 4-bit counter cleared on entry, then go SAMPLE.
REQ-020 SAMPLE (one cycle): register ioctl_din into dout, set dout_valid, set dout_last if address is the last byte of the last enabled region, go HOLD.
REQ-021 HOLD: dout, dout_valid, dout_last SHALL stay stable until dout_valid&dout_ready; on that edge clear dout_valid/dout_last; if address is region end -> SEEK, else increment ioctl_addr and -> ADDR.
REQ-022 Minimum per-byte period SHALL be WAIT+2 cycles with dout_ready held high.
REQ-023 FINISH (one cycle): pulse done, clear busy on following edge, go IDLE.
REQ-024 region_en latched as 0 SHALL produce no bytes; SEEK->FINISH; done two cycles after start accepted.
REQ-025 ioctl_addr SHALL never leave the enabled region currently being walked; 16-bit increment never wraps (region ends precede 0xFFFF).
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on next edge: dout_valid, dout_last, busy cleared, no done pulse; ioctl_addr holds last value; abort has priority over start and over dout_ready.
REQ-027 ioctl_addr SHALL hold its value in IDLE.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE: ioctl_addr=0x0000, dout=0x00, dout_valid=0, dout_last=0, busy=0, done=0, latched region_en=0, wait counter=0; mid-dump reset discards the dump with no done.

Verification
REQ-029 region_en=4'b0100, WAIT=2, ready tied 1, RAM model returns addr[7:0] -> 4096 bytes, addresses 0x9000..0x9FFF, dout=0x00,0x01,..; last byte 0xFF with dout_last; done one pulse; per-byte period 4 cycles.
REQ-030 region_en=4'b1010 -> char 0x8000-0x8FFF then object 0xA000-0xA7FF, 6144 bytes, dout_last only on 0xA7FF, VRAM/palette addresses never driven.
REQ-031 region_en=4'b0100, random dout_ready backpressure -> dout stable while valid&!ready; byte sequence identical to REQ-029; no byte lost or duplicated.
REQ-032 abort at byte 100 of VRAM dump -> next cycle busy=0, dout_valid=0, done never pulses; subsequent start with 4'b1000 dumps 2048 bytes from 0xA000.
REQ-033 start with region_en=0 -> busy high two cycles, done pulses, zero bytes; start pulsed mid-dump -> ignored, byte count unchanged.
REQ-034 rst_n low for one cycle mid-dump -> all outputs at REQ-028 values next cycle; no done.

Source files
------------

// File: rtl/jts16_shadow_dump.sv
// Walks the enabled shadow-RAM regions (VRAM, char, palette, object) in order,
// reading one byte per address and handing it out over a valid/ready stream.
module jts16_shadow_dump #(
    parameter int unsigned WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  region_en,
    output logic [15:0] ioctl_addr,
    input  logic [7:0]  ioctl_din,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_ADDR,
        S_SAMPLE,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [15:0] r_end;
    logic [7:0]  r_dout;
    logic        r_valid;
    logic        r_last;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_pending;
    logic [3:0]  r_wait_cnt;
    logic        r_last_region;

    logic        w_found;
    logic [1:0]  w_idx;
    logic [3:0]  w_rest;
    logic [15:0] w_base;
    logic [15:0] w_end;
    logic        w_at_end;
    logic        w_wait_done;

    // Lowest-order region still pending is walked next.
    always_comb begin
        w_found = 1'b1;
        w_idx   = 2'd0;
        casez (r_pending)
            4'b???1: w_idx = 2'd0;
            4'b??10: w_idx = 2'd1;
            4'b?100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_found = 1'b0;
        endcase
        w_rest = r_pending & ~(4'b0001 << w_idx);
        case (w_idx)
            2'd0:    begin w_base = 16'h0000; w_end = 16'h7FFF; end
            2'd1:    begin w_base = 16'h8000; w_end = 16'h8FFF; end
            2'd2:    begin w_base = 16'h9000; w_end = 16'h9FFF; end
            default: begin w_base = 16'hA000; w_end = 16'hA7FF; end
        endcase
    end

    assign w_at_end    = (r_addr == r_end);
    assign w_wait_done = (r_wait_cnt == 4'(WAIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_end         <= '0;
            r_dout        <= '0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pending     <= '0;
            r_wait_cnt    <= '0;
            r_last_region <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_pending <= region_en;
                        r_busy    <= 1'b1;
                        r_state   <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (w_found) begin
                        r_addr        <= w_base;
                        r_end         <= w_end;
                        r_pending     <= w_rest;
                        r_last_region <= (w_rest == 4'b0000);
                        r_wait_cnt    <= '0;
                        r_state       <= S_ADDR;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_ADDR: begin
                    if (w_wait_done) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_dout  <= ioctl_din;
                    r_valid <= 1'b1;
                    r_last  <= r_last_region && w_at_end;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_valid && dout_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (w_at_end) begin
                            r_state <= S_SEEK;
                        end else begin
                            r_addr     <= r_addr + 16'd1;
                            r_wait_cnt <= '0;
                            r_state    <= S_ADDR;
                        end
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ioctl_addr = r_addr;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
